// File: rtl/fnd_time_display.sv
// fnd_time_display: scans a 4-digit common-anode 7-segment display with
// stopwatch time. sw_mode=0 shows sec.msec, sw_mode=1 shows hour.min.
// A separator dot on digit 2 blinks at 1 Hz, derived from msec.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks digit 3 when it is 0.
module fnd_time_display #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_mode,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int unsigned DIV = CLK_FREQ / SCAN_HZ;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] tick_cnt;
  logic [1:0]       digit_sel;
  logic             tick;
  logic [1:0]       next_sel;
  logic [6:0]       pair_val;
  logic [3:0]       digit;
  logic [6:0]       seg;
  logic             dp;

  // Active-low gfedcba pattern for one decimal digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  // Tens digit folded to 0..9 so out-of-range values still show two digits.
  function automatic logic [3:0] tens_of(input logic [6:0] v);
    tens_of = 4'((v / 7'd10) % 7'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    ones_of = 4'(v % 7'd10);
  endfunction

  assign tick = (tick_cnt == CNT_MAX);

  // Select and encode the digit that becomes visible at the coming tick.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    next_sel = digit_sel + 2'd1;
    if (next_sel[1]) begin
      pair_val = sw_mode ? {2'b00, hour} : {1'b0, sec};
    end else begin
      pair_val = sw_mode ? {1'b0, min} : msec;
    end
    digit = next_sel[0] ? tens_of(pair_val) : ones_of(pair_val);
    seg   = seg_code(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if ((next_sel == 2'd3) && (digit == 4'd0)) begin
      seg = 7'h7F;
    end
`endif
    // Dot lit during the first half of every second, on digit 2 only.
    dp = ~((next_sel == 2'd2) && (msec < 7'd50));
  end

  // Prescaler, scan sequencer and registered display outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      tick_cnt  <= '0;
      digit_sel <= 2'd0;
      fnd_com   <= 4'b1111;
      fnd_data  <= 8'hFF;
    end else begin
      if (tick) begin
        tick_cnt  <= '0;
        digit_sel <= next_sel;
        fnd_com   <= ~(4'b0001 << next_sel);
        fnd_data  <= {dp, seg};
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule
